// File: rtl/ncl_ring_ctrl_if.sv
// ncl_ring_ctrl_if: data/ack rails and init line between a self-timed NCL ring and its clocked supervisor
interface ncl_ring_ctrl_if #(
  parameter int W = 16
);
  logic [W-1:0] d;
  logic         dk;
  logic         init;
  modport master (output init, input d, dk);
  modport slave  (input init, output d, dk);
endinterface

// File: rtl/ncl_ring_ctrl.sv
// ncl_ring_ctrl: sequences NCL ring init, counts DATA wavefronts, measures period, checks one-hot, watchdogs stalls
module ncl_ring_ctrl #(
  parameter int W            = 16,
  parameter int CW           = 16,
  parameter int INIT_CYCLES  = 8,
  parameter int TIMEOUT      = 1024,
  parameter int AUTO_RESTART = 0
) (
  input  logic                  clk,
  input  logic                  init_n,
  input  logic                  start,
  input  logic                  stop,
  ncl_ring_ctrl_if.master       ring,
  output logic                  running,
  output logic                  stalled,
  output logic                  err,
  output logic [CW-1:0]         tok_cnt,
  output logic [CW-1:0]         last_period
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, INIT, RUN, STALL} state_t;

  state_t        state;
  logic          dk_m, dk_s, dk_p;
  logic [W-1:0]  d_m, d_s;
  logic [IW-1:0] init_cnt;
  logic [WW-1:0] wd;
  logic [CW-1:0] per;
  logic          seen, pend, init_q;
  logic          data_edge, null_edge, restart;

  assign ring.init = init_q;
  assign data_edge = dk_p & ~dk_s;
  assign null_edge = ~dk_p & dk_s;
  assign restart   = start || (state == STALL && AUTO_RESTART != 0);

  // two-flop synchronizers for the async rails plus the previous synced ack for edge detection
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      dk_m <= 1'b0;
      dk_s <= 1'b0;
      dk_p <= 1'b0;
      d_m  <= '0;
      d_s  <= '0;
    end else begin
      dk_m <= ring.dk;
      dk_s <= dk_m;
      dk_p <= dk_s;
      d_m  <= ring.d;
      d_s  <= d_m;
    end

  // supervisor FSM: start wins over stop, stop wins over edges and watchdog expiry
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      state       <= IDLE;
      init_q      <= 1'b1;
      running     <= 1'b0;
      stalled     <= 1'b0;
      err         <= 1'b0;
      tok_cnt     <= '0;
      last_period <= '0;
      init_cnt    <= '0;
      wd          <= '0;
      per         <= '0;
      seen        <= 1'b0;
      pend        <= 1'b0;
    end else if (restart) begin
      state       <= INIT;
      init_q      <= 1'b1;
      running     <= 1'b0;
      stalled     <= 1'b0;
      err         <= 1'b0;
      tok_cnt     <= '0;
      last_period <= '0;
      init_cnt    <= '0;
      wd          <= '0;
      per         <= '0;
      seen        <= 1'b0;
      pend        <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (pend && !$onehot(d_s)) err <= 1'b1;
      case (state)
        INIT:
          if (init_cnt == IW'(INIT_CYCLES - 1)) begin
            state   <= RUN;
            init_q  <= 1'b0;
            running <= 1'b1;
          end else begin
            init_cnt <= init_cnt + IW'(1);
          end
        RUN:
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (data_edge) begin
            wd      <= '0;
            tok_cnt <= (tok_cnt == CMAX) ? tok_cnt : tok_cnt + CW'(1);
            if (seen) last_period <= per;
            per     <= CW'(1);
            seen    <= 1'b1;
            pend    <= 1'b1;
          end else begin
            per <= (per == CMAX) ? per : per + CW'(1);
            wd  <= null_edge ? '0 : wd + WW'(1);
            if (!null_edge && wd == WW'(TIMEOUT - 1)) begin
              state   <= STALL;
              running <= 1'b0;
              stalled <= 1'b1;
            end
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_ncl_ring_ctrl.sv
// tb_ncl_ring_ctrl: directed ring stimulus against three controller variants with a timestamp-based reference model
module tb_ncl_ring_ctrl;
  localparam int NI    = 3;
  localparam int INITC = 8;
  localparam int TO    = 1024;
  localparam int M_IDLE = 0, M_INIT = 1, M_RUN = 2, M_STALL = 3;

  logic        clk = 1'b0;
  logic        init_n, start, stop;
  logic [15:0] ring_d;
  logic        ring_dk;
  logic        ri[NI], run[NI], stl[NI], er[NI];
  logic [15:0] tc[NI], lpv[NI];
  logic [3:0]  tc2, lp2;
  bit          chk_en = 1'b0;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  ncl_ring_ctrl_if #(16) r0 ();
  ncl_ring_ctrl_if #(16) r1 ();
  ncl_ring_ctrl_if #(16) r2 ();
  assign r0.d = ring_d;
  assign r0.dk = ring_dk;
  assign r1.d = ring_d;
  assign r1.dk = ring_dk;
  assign r2.d = ring_d;
  assign r2.dk = ring_dk;
  assign ri[0] = r0.init;
  assign ri[1] = r1.init;
  assign ri[2] = r2.init;
  assign tc[2] = {12'd0, tc2};
  assign lpv[2] = {12'd0, lp2};

  ncl_ring_ctrl #(.W(16), .CW(16), .INIT_CYCLES(INITC), .TIMEOUT(TO), .AUTO_RESTART(0)) u0 (
    .clk(clk), .init_n(init_n), .start(start), .stop(stop), .ring(r0),
    .running(run[0]), .stalled(stl[0]), .err(er[0]), .tok_cnt(tc[0]), .last_period(lpv[0]));
  ncl_ring_ctrl #(.W(16), .CW(16), .INIT_CYCLES(INITC), .TIMEOUT(TO), .AUTO_RESTART(1)) u1 (
    .clk(clk), .init_n(init_n), .start(start), .stop(stop), .ring(r1),
    .running(run[1]), .stalled(stl[1]), .err(er[1]), .tok_cnt(tc[1]), .last_period(lpv[1]));
  ncl_ring_ctrl #(.W(16), .CW(4), .INIT_CYCLES(INITC), .TIMEOUT(TO), .AUTO_RESTART(0)) u2 (
    .clk(clk), .init_n(init_n), .start(start), .stop(stop), .ring(r2),
    .running(run[2]), .stalled(stl[2]), .err(er[2]), .tok_cnt(tc2), .last_period(lp2));

  // reference model: phase plus cycle timestamps of the events that matter
  int          cyc;
  int          mode[NI], t_init[NI], toks[NI], last_act[NI], prev_data[NI], lp[NI];
  bit          merr[NI], pend[NI], hold[NI];
  bit          hk[4];
  logic [15:0] hd[4];

  function automatic int cw_of(int i);
    return (i == 2) ? 4 : 16;
  endfunction

  function automatic int sat(int v, int i);
    int mx;
    mx = (1 << cw_of(i)) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic mreset();
    for (int i = 0; i < NI; i++) begin
      mode[i] = M_IDLE;
      toks[i] = 0;
      lp[i] = 0;
      merr[i] = 0;
      pend[i] = 0;
      hold[i] = 0;
      prev_data[i] = -1;
      last_act[i] = 0;
      t_init[i] = 0;
    end
    for (int j = 0; j < 4; j++) begin
      hk[j] = 0;
      hd[j] = '0;
    end
  endtask

  task automatic mstep();
    bit dat, nul;
    cyc++;
    for (int j = 3; j > 0; j--) begin
      hk[j] = hk[j-1];
      hd[j] = hd[j-1];
    end
    hk[0] = ring_dk;
    hd[0] = ring_d;
    dat = hk[3] && !hk[2];
    nul = !hk[3] && hk[2];
    for (int i = 0; i < NI; i++) begin
      if (start || (mode[i] == M_STALL && i == 1)) begin
        mode[i] = M_INIT;
        t_init[i] = cyc;
        toks[i] = 0;
        lp[i] = 0;
        merr[i] = 0;
        pend[i] = 0;
        prev_data[i] = -1;
        hold[i] = 0;
      end else begin
        if (pend[i] && $countones(hd[2]) != 1) merr[i] = 1;
        pend[i] = 0;
        if (mode[i] == M_INIT && cyc - t_init[i] >= INITC) begin
          mode[i] = M_RUN;
          last_act[i] = cyc;
        end else if (mode[i] == M_RUN) begin
          if (stop) begin
            mode[i] = M_IDLE;
            hold[i] = 1;
          end else if (dat) begin
            toks[i]++;
            if (prev_data[i] >= 0) lp[i] = cyc - prev_data[i];
            prev_data[i] = cyc;
            pend[i] = 1;
            last_act[i] = cyc;
          end else if (nul) begin
            last_act[i] = cyc;
          end else if (cyc - last_act[i] >= TO) begin
            mode[i] = M_STALL;
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge init_n)
    if (!init_n) mreset();
    else mstep();

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en)
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("u%0d.ring_init", i), int'(ri[i]), int'((mode[i] == M_IDLE && !hold[i]) || mode[i] == M_INIT));
        chk($sformatf("u%0d.running", i), int'(run[i]), int'(mode[i] == M_RUN));
        chk($sformatf("u%0d.stalled", i), int'(stl[i]), int'(mode[i] == M_STALL));
        chk($sformatf("u%0d.err", i), int'(er[i]), int'(merr[i]));
        chk($sformatf("u%0d.tok_cnt", i), int'(tc[i]), sat(toks[i], i));
        chk($sformatf("u%0d.last_period", i), int'(lpv[i]), sat(lp[i], i));
      end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic tokens(int n, int bad);
    logic [15:0] w;
    for (int k = 0; k < n; k++) begin
      w = 16'h0001 << (k % 16);
      ring_d = (k == bad) ? 16'h0006 : w;
      ring_dk = 1'b0;
      repeat (10) @(negedge clk);
      ring_d = '0;
      ring_dk = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    init_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    ring_d = '0;
    ring_dk = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst.ring_init", int'(ri[0]), 1);
    chk("rst.running", int'(run[0]), 0);
    chk("rst.tok_cnt", int'(tc[0]), 0);
    init_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (7) @(negedge clk);
    chk("init.held", int'(ri[0]), 1);
    @(negedge clk);
    chk("init.released", int'(ri[0]), 0);
    chk("init.running", int'(run[0]), 1);
    tokens(5, -1);
    chk("t1.tok_cnt", int'(tc[0]), 5);
    chk("t1.last_period", int'(lpv[0]), 20);
    chk("t1.err", int'(er[0]), 0);
    tokens(3, 1);
    chk("t2.err_sticky", int'(er[0]), 1);
    chk("t2.tok_cnt", int'(tc[0]), 8);
    pulse_start();
    chk("t2.err_cleared", int'(er[0]), 0);
    chk("t2.tok_cleared", int'(tc[0]), 0);
    repeat (8) @(negedge clk);
    tokens(20, -1);
    chk("t4.tok_sat", int'(tc[2]), 15);
    chk("t4.period_sat", int'(lpv[2]), 15);
    chk("t4.tok_wide", int'(tc[0]), 20);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("t5.ring_init", int'(ri[0]), 1);
    chk("t5.tok_cnt", int'(tc[0]), 0);
    chk("t5.last_period", int'(lpv[0]), 0);
    repeat (8) @(negedge clk);
    tokens(2, -1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop.ring_init", int'(ri[0]), 0);
    chk("stop.running", int'(run[0]), 0);
    chk("stop.tok_hold", int'(tc[0]), 2);
    tokens(1, -1);
    chk("stop.tok_idle", int'(tc[0]), 2);
    pulse_start();
    repeat (8) @(negedge clk);
    tokens(2, -1);
    k = 0;
    while (!stl[0] && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("t3.stall_latency", k, 1017);
    chk("t3.ar_stalled", int'(stl[1]), 1);
    @(negedge clk);
    chk("t3.ar_reinit", int'(ri[1]), 1);
    chk("t3.ar_unstall", int'(stl[1]), 0);
    chk("t3.parked", int'(stl[0]), 1);
    chk("t3.parked_init", int'(ri[0]), 0);
    repeat (20) @(negedge clk);
    pulse_start();
    repeat (8) @(negedge clk);
    tokens(2, -1);
    #3 init_n = 1'b0;
    #1;
    chk("t6.ring_init", int'(ri[0]), 1);
    chk("t6.running", int'(run[0]), 0);
    chk("t6.tok_cnt", int'(tc[0]), 0);
    chk("t6.last_period", int'(lpv[0]), 0);
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
